// File: rtl/spi_master_m3_if.sv
// Parallel-side handshake and serial SPI pins of the mode-3 master, grouped so the
// master and its host or bus model connect through one port.
interface spi_master_m3_if;
    logic        start;
    logic [15:0] tdata;
    logic        miso;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        ss;
    logic        sck;
    logic        mosi;

    modport master (
        input  start, tdata, miso,
        output busy, done, rdata, ss, sck, mosi
    );

    modport slave (
        output start, tdata, miso,
        input  busy, done, rdata, ss, sck, mosi
    );
endinterface

// File: rtl/spi_master_m3.sv
// 16-bit SPI mode-3 master (CPOL=1, CPHA=1): one word out on mosi and one word in
// from miso per accepted start. The sck half-period is CLK_DIV clk cycles.
module spi_master_m3 #(
    parameter int unsigned CLK_DIV = 4,
    parameter bit          MLB     = 1'b1
) (
    input  logic            clk,
    input  logic            rstb,
    spi_master_m3_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [7:0]  div, div_n;
    logic [4:0]  cnt, cnt_n;
    logic [15:0] tx, tx_n, rx, rx_n;
    logic [15:0] rdata_r, rdata_n;
    logic        sck_r, sck_n, mosi_r, mosi_n, ss_r, ss_n;
    logic        busy_r, busy_n, done_r, done_n;
    logic        tick;
    logic [15:0] tx_shift;

    function automatic logic first_bit(input logic [15:0] w);
        return MLB ? w[15] : w[0];
    endfunction

    // Received bits enter at the end opposite to the one transmitted first.
    function automatic logic [15:0] rx_insert(input logic [15:0] w, input logic b);
        return MLB ? {w[14:0], b} : {b, w[15:1]};
    endfunction

    assign tick     = (div == DIV_LAST);
    assign tx_shift = MLB ? {tx[14:0], 1'b1} : {1'b1, tx[15:1]};

    always_comb begin
        state_n = state;
        div_n   = tick ? 8'd0 : div + 8'd1;
        cnt_n   = cnt;
        tx_n    = tx;
        rx_n    = rx;
        rdata_n = rdata_r;
        sck_n   = sck_r;
        mosi_n  = mosi_r;
        ss_n    = ss_r;
        busy_n  = busy_r;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                div_n = 8'd0;
                if (bus.start) begin
                    state_n = SETUP;
                    tx_n    = bus.tdata;
                    rx_n    = 16'h0000;
                    cnt_n   = 5'd0;
                    ss_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_n = LOW;
                    sck_n   = 1'b0;
                    mosi_n  = first_bit(tx);
                end
            end
            LOW: begin
                if (tick) begin
                    state_n = HIGH;
                    sck_n   = 1'b1;
                    rx_n    = rx_insert(rx, bus.miso);
                    cnt_n   = cnt + 5'd1;
                end
            end
            HIGH: begin
                if (tick) begin
                    if (cnt == 5'd16) begin
                        state_n = HOLD;
                    end else begin
                        state_n = LOW;
                        sck_n   = 1'b0;
                        tx_n    = tx_shift;
                        mosi_n  = first_bit(tx_shift);
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_n = GAP;
                    ss_n    = 1'b1;
                    mosi_n  = 1'b1;
                    rdata_n = rx;
                    done_n  = 1'b1;
                end
            end
            GAP: begin
                // Keeps ss high for at least one half-period between frames.
                if (tick) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            div     <= 8'd0;
            cnt     <= 5'd0;
            tx      <= 16'h0000;
            rx      <= 16'h0000;
            rdata_r <= 16'h0000;
            sck_r   <= 1'b1;
            mosi_r  <= 1'b1;
            ss_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            div     <= div_n;
            cnt     <= cnt_n;
            tx      <= tx_n;
            rx      <= rx_n;
            rdata_r <= rdata_n;
            sck_r   <= sck_n;
            mosi_r  <= mosi_n;
            ss_r    <= ss_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
        end
    end

    assign bus.sck   = sck_r;
    assign bus.mosi  = mosi_r;
    assign bus.ss    = ss_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.rdata = rdata_r;
endmodule

// File: tb/tb_spi_master_m3.sv
// Bench for spi_master_m3: three instances (D=4 MSB-first, D=4 LSB-first, D=2 MSB-first),
// each with a mode-3 slave model, driven from a vector table plus corner-case sequences.
module tb_spi_master_m3;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        start_drv = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] tdata_drv = 16'h0000;
    int          sel = 0;
    int          n_chk = 0;
    int          n_err = 0;

    logic [15:0] slave_word [3];
    logic [2:0]  sck_v, ss_v, mosi_v, miso_v, busy_v, done_v;
    logic [15:0] rdata_v [3];
    logic [15:0] cap_v [3];
    int          pul_v [3];
    int          dn_v [3];

    spi_master_m3_if if_a ();
    spi_master_m3_if if_b ();
    spi_master_m3_if if_c ();

    spi_master_m3 #(.CLK_DIV(4), .MLB(1'b1)) dut_a (.clk(clk), .rstb(rstb), .bus(if_a));
    spi_master_m3 #(.CLK_DIV(4), .MLB(1'b0)) dut_b (.clk(clk), .rstb(rstb), .bus(if_b));
    spi_master_m3 #(.CLK_DIV(2), .MLB(1'b1)) dut_c (.clk(clk), .rstb(rstb), .bus(if_c));

    always #5 clk = ~clk;

    assign if_a.start = start_drv && (sel == 0);
    assign if_b.start = start_drv && (sel == 1);
    assign if_c.start = start_drv && (sel == 2);
    assign if_a.tdata = tdata_drv;
    assign if_b.tdata = tdata_drv;
    assign if_c.tdata = tdata_drv;
    assign if_a.miso  = miso_v[0];
    assign if_b.miso  = miso_v[1];
    assign if_c.miso  = miso_v[2];

    assign sck_v  = {if_c.sck,  if_b.sck,  if_a.sck};
    assign ss_v   = {if_c.ss,   if_b.ss,   if_a.ss};
    assign mosi_v = {if_c.mosi, if_b.mosi, if_a.mosi};
    assign busy_v = {if_c.busy, if_b.busy, if_a.busy};
    assign done_v = {if_c.done, if_b.done, if_a.done};
    assign rdata_v[0] = if_a.rdata;
    assign rdata_v[1] = if_b.rdata;
    assign rdata_v[2] = if_c.rdata;

    // Mode-3 slave: drives the next bit after each sck fall, samples mosi after each rise.
    for (genvar k = 0; k < 3; k++) begin : g_slv
        localparam bit LSBF = (k == 1);
        logic        sck_d  = 1'b1;
        logic        miso_r = 1'b1;
        logic [15:0] cap    = 16'h0000;
        int          nbit   = 0;
        int          pul    = 0;
        int          dn     = 0;
        always @(posedge clk) begin
            sck_d <= sck_v[k];
            if (clr) begin
                nbit   <= 0;
                pul    <= 0;
                dn     <= 0;
                cap    <= 16'h0000;
                miso_r <= 1'b1;
            end else begin
                if (done_v[k]) dn <= dn + 1;
                if (!ss_v[k] && sck_d && !sck_v[k]) begin
                    miso_r <= LSBF ? slave_word[k][nbit[3:0]] : slave_word[k][4'd15 - nbit[3:0]];
                    nbit   <= nbit + 1;
                end
                if (!ss_v[k] && !sck_d && sck_v[k]) begin
                    cap <= LSBF ? {mosi_v[k], cap[15:1]} : {cap[14:0], mosi_v[k]};
                    pul <= pul + 1;
                end
            end
        end
        assign miso_v[k] = miso_r;
        assign cap_v[k]  = cap;
        assign pul_v[k]  = pul;
        assign dn_v[k]   = dn;
    end

    typedef struct {
        int          s;
        logic [15:0] td;
        logic [15:0] sw;
        int          d;
        logic [15:0] exp_rd;
        int          exp_done;
        int          exp_bf;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full frame on instance s; returns with the cycle where busy fell still current.
    task automatic run_frame(input string tag, input int s, input logic [15:0] td,
                             input logic [15:0] sw, input int d, input logic [15:0] exp_rd,
                             input int exp_done, input int exp_bf, input bit mid);
        int   cyc, done_at, fall1, fall2, bf;
        logic prev_sck, ss_at_done, ss_glitch;
        slave_word[s] = sw;
        sel           = s;
        tdata_drv     = td;
        @(negedge clk);
        start_drv = 1'b1;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        clr       = 1'b0;
        cyc       = 1;
        chk({tag, "_c1_ss"},   32'(ss_v[s]),   32'd0);
        chk({tag, "_c1_busy"}, 32'(busy_v[s]), 32'd1);
        chk({tag, "_c1_sck"},  32'(sck_v[s]),  32'd1);
        done_at = -1; fall1 = -1; fall2 = -1; bf = -1;
        prev_sck = 1'b1; ss_at_done = 1'b0; ss_glitch = 1'b0;
        while (bf < 0 && cyc < 40 * d + 20) begin
            if (done_v[s] && done_at < 0) begin
                done_at    = cyc;
                ss_at_done = ss_v[s];
            end
            if (done_at >= 0 && !ss_v[s]) ss_glitch = 1'b1;
            if (prev_sck && !sck_v[s]) begin
                if (fall1 < 0) fall1 = cyc;
                else if (fall2 < 0) fall2 = cyc;
            end
            prev_sck = sck_v[s];
            if (!busy_v[s]) begin
                bf = cyc;
            end else begin
                start_drv = mid && (cyc == 50);
                if (mid && cyc == 50) tdata_drv = 16'h1234;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start_drv = 1'b0;
        chk({tag, "_fall1"},     32'(fall1),        32'(1 + d));
        chk({tag, "_period"},    32'(fall2 - fall1), 32'(2 * d));
        chk({tag, "_done_cyc"},  32'(done_at),      32'(exp_done));
        chk({tag, "_ss_done"},   32'(ss_at_done),   32'd1);
        chk({tag, "_ss_gap"},    32'(ss_glitch),    32'd0);
        chk({tag, "_rdata"},     32'(rdata_v[s]),   32'(exp_rd));
        chk({tag, "_mosi"},      32'(cap_v[s]),     32'(td));
        chk({tag, "_pulses"},    32'(pul_v[s]),     32'd16);
        chk({tag, "_done_cnt"},  32'(dn_v[s]),      32'd1);
        chk({tag, "_busy_fall"}, 32'(bf),           32'(exp_bf));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int busy_seen;
        vecs[0] = '{0, 16'hA5C3, 16'h3C5A, 4, 16'h3C5A, 137, 141};
        vecs[1] = '{1, 16'h0001, 16'h8000, 4, 16'h8000, 137, 141};
        vecs[2] = '{2, 16'hFFFF, 16'h0000, 2, 16'h0000,  69,  71};
        vecs[3] = '{0, 16'h1234, 16'hFEDC, 4, 16'hFEDC, 137, 141};
        vecs[4] = '{1, 16'hBEEF, 16'h1357, 4, 16'h1357, 137, 141};
        for (int k = 0; k < 3; k++) slave_word[k] = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss",    32'(ss_v[0]),    32'd1);
        chk("rst_sck",   32'(sck_v[0]),   32'd1);
        chk("rst_mosi",  32'(mosi_v[0]),  32'd1);
        chk("rst_busy",  32'(busy_v[0]),  32'd0);
        chk("rst_done",  32'(done_v[0]),  32'd0);
        chk("rst_rdata", 32'(rdata_v[0]), 32'h0000);
        @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("v%0d", i), vecs[i].s, vecs[i].td, vecs[i].sw, vecs[i].d,
                      vecs[i].exp_rd, vecs[i].exp_done, vecs[i].exp_bf, 1'b0);
            repeat (3) @(posedge clk);
        end

        // Start pulsed mid-frame must neither alter the frame nor queue a second one.
        run_frame("busy_start", 0, 16'hFFFF, 16'h0F0F, 4, 16'h0F0F, 137, 141, 1'b1);
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (busy_v[0] || !ss_v[0]) busy_seen++;
        end
        chk("busy_start_no_queue", 32'(busy_seen), 32'd0);

        run_frame("b2b_a", 0, 16'h55AA, 16'hC33C, 4, 16'hC33C, 137, 141, 1'b0);
        chk("b2b_ss_high", 32'(ss_v[0]), 32'd1);
        run_frame("b2b_b", 0, 16'h0FF0, 16'h9669, 4, 16'h9669, 137, 141, 1'b0);
        repeat (3) @(posedge clk);

        // Asynchronous reset at cycle 60 of a frame.
        slave_word[0] = 16'h00FF;
        sel           = 0;
        tdata_drv     = 16'hC0DE;
        @(negedge clk);
        start_drv = 1'b1;
        clr       = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        clr       = 1'b0;
        repeat (59) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(busy_v[0]), 32'd1);
        #2;
        rstb = 1'b0;
        #1;
        chk("mid_rst_ss",    32'(ss_v[0]),    32'd1);
        chk("mid_rst_sck",   32'(sck_v[0]),   32'd1);
        chk("mid_rst_mosi",  32'(mosi_v[0]),  32'd1);
        chk("mid_rst_busy",  32'(busy_v[0]),  32'd0);
        chk("mid_rst_done",  32'(done_v[0]),  32'd0);
        chk("mid_rst_rdata", 32'(rdata_v[0]), 32'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(posedge clk);
        run_frame("post_rst", 0, 16'h6B2D, 16'h94D2, 4, 16'h94D2, 137, 141, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/spi_master_m3.md
# spi_master_m3

16-bit SPI mode-3 master (CPOL=1, CPHA=1) that drives the board's SPI slave link from the system clock. It takes a parallel word on a start strobe, shifts it out on `mosi` while capturing `miso`, and returns the received word with a one-cycle done pulse. It sits between the Doppler control logic and any 16-bit mode-3 slave on the same bus, and is bit-compatible with our 16-bit SPI slave: exactly 16 SCK cycles per frame, MSB- or LSB-first selectable.

## Interface
- `CLK_DIV`, 4: SCK half-period in `clk` cycles; legal range 2..255.
- `MLB`, 1: 1 = MSB first (bit 15 first); 0 = LSB first (bit 0 first). Applies to both directions.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only when `busy`=0.
- `tdata`  in  16  word to transmit; captured on the accepted `start` cycle.
- `miso`  in  1  serial data from the slave; may be Z/X while `ss`=1.
- `busy`  out  1  high from the cycle after an accepted `start` until the inter-frame gap ends.
- `done`  out  1  one-cycle pulse; `rdata` is valid from this cycle on.
- `rdata`  out  16  last received word, held until the next `done`.
- `ss`  out  1  active-low slave select.
- `sck`  out  1  SPI clock; idles high.
- `mosi`  out  1  master-out data; idles high.

## Operation
- All outputs are registered. Reset values: `ss`=1, `sck`=1, `mosi`=1, `busy`=0, `done`=0, `rdata`=16'h0000, FSM=IDLE, bit counter=0, divider=0.
- FSM states are IDLE, SETUP, LOW, HIGH, HOLD and GAP.
- **IDLE:** when `start`=1, latch `tdata` into the TX shift register, clear the RX shift register, and go to SETUP. `ss` goes low and `busy` goes high on the next cycle.
- **SETUP:** hold for `CLK_DIV` cycles with `sck`=1, then go to LOW.
  - On LOW entry, `sck` falls and `mosi` takes the first bit: `tdata[15]` if `MLB`=1, else `tdata[0]`.
- **LOW:** hold for `CLK_DIV` cycles, then go to HIGH.
  - On HIGH entry, `sck` rises and `miso` is sampled into the RX shift register.
  - If `MLB`=1, shift in at the LSB (left shift). If `MLB`=0, shift in at the MSB (right shift).
  - The bit counter increments.
- **HIGH:** hold for `CLK_DIV` cycles. If the counter is below 16, go to LOW: `sck` falls, the TX register shifts and `mosi` takes the next bit. If the counter is 16, go to HOLD.
  - The TX register shifts with 1-fill, so `mosi` returns to 1 after the last bit.
- **HOLD:** hold for `CLK_DIV` cycles with `sck`=1, then go to GAP.
  - On GAP entry: `ss`=1 and `mosi`=1; `rdata` is loaded from the RX register; `done` pulses for one cycle.
- **GAP:** hold for `CLK_DIV` cycles (minimum `ss` high time), then go to IDLE and drop `busy`.
- Every frame is exactly 16 falling and 16 rising `sck` edges. There are no partial frames.
- `start` is ignored while `busy`=1; it is not queued.
- `tdata` changes after the start cycle have no effect on the current frame.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately.
  - No `done` pulse is generated and `rdata` is cleared.
  - The slave's bit count desynchronises; system software must pulse the slave's reset as well.
- `miso` is used only at HIGH-entry sample points, so Z/X elsewhere is harmless.

## Timing
- Let D = `CLK_DIV` and let cycle 0 be the `clk` edge that samples `start`=1.
- Cycle 1: `ss`=0, `busy`=1, `sck`=1.
- Falling edge k (k=1..16): `sck`=0 at cycle 1+D+2D(k-1).
- Rising edge k: `sck`=1 at cycle 1+2Dk, with the `miso` sample taken on that same `clk` edge.
- Setup and hold margins:
  - MOSI setup to the slave's rising-edge sample is D cycles.
  - `miso` must be valid within D cycles of the falling edge.
- `done`=1 and `ss`=1 at cycle 1+34D. Round-trip latency is 34D+1 cycles (137 at D=4).
- `busy`=0 at cycle 1+35D. The earliest next accepted `start` is that cycle, so back-to-back frames run every 35D+1 cycles.
- `sck` duty cycle is exactly 50%; the period is 2D `clk` cycles.

## Test plan
- **MSB-first loopback.** D=4, `MLB`=1, `tdata`=16'hA5C3, with a mode-3 slave model that returns 16'h3C5A.
  - `mosi` bits at the rising edges are 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - `rdata`=16'h3C5A with `done` at cycle 137.
  - Exactly 16 `sck` pulses occur while `ss`=0.
- **LSB-first.** `MLB`=0, `tdata`=16'h0001, slave returns 16'h8000.
  - The first `mosi` bit is 1 and the rest are 0.
  - `rdata`=16'h8000.
- **Start while busy.** Pulse `start` with `tdata`=16'h1234 at cycle 50 of a frame carrying 16'hFFFF.
  - The current frame is unchanged and no second frame starts.
  - `busy` falls at cycle 141.
- **Back-to-back frames.** Assert `start` on the cycle `busy` falls.
  - `ss` stays high for at least D cycles between frames.
  - Both `rdata` values are correct and each frame produces exactly one `done`.
- **Reset mid-frame.** Drop `rstb` at cycle 60.
  - `ss`=1, `sck`=1, `mosi`=1, `busy`=0, `done`=0 and `rdata`=0 follow asynchronously.
  - A fresh frame after reset release completes normally.
- **Minimum divider.** D=2, `tdata`=16'hFFFF, slave returns 16'h0000.
  - `sck` period is 4 cycles.
  - `done` at cycle 69 with `rdata`=16'h0000.
